// File: rtl/dmi_pkg.sv
// Shared DMI definitions: op codes, sticky status codes, sequencer state encoding.
package dmi_pkg;

  localparam int unsigned DMI_OP_W   = 2;
  localparam int unsigned DMI_STAT_W = 2;

  typedef enum logic [DMI_OP_W-1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [DMI_STAT_W-1:0] {
    DMI_STAT_OK     = 2'd0,
    DMI_STAT_FAILED = 2'd2,
    DMI_STAT_BUSY   = 2'd3
  } dmi_stat_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } dmi_state_e;

  // True for the ops that produce an APB transfer.
  function automatic logic dmi_op_is_bus(input logic [DMI_OP_W-1:0] op);
    return (op == DMI_OP_READ) || (op == DMI_OP_WRITE);
  endfunction

endpackage

// File: rtl/dmi_apb_master_if.sv
// APB bus bundle between the DMI sequencer (master) and the debug-module fabric (slave).
interface dmi_apb_master_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
) ();

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/dmi_timeout_counter.sv
// ACCESS-phase watchdog: counts stalled cycles and flags the last permitted one.
// expired_o is registered and high during the LIMIT-th consecutive stalled cycle.
module dmi_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired_q, expired_d;

  // Saturating count; flag is raised one cycle ahead so the FSM exits on the LIMIT-th stall.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
    expired_d = (cnt_d == CNT_LAST);
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/dmi_apb_master.sv
// DMI access sequencer: turns one-shot DTM requests into single APB transfers,
// captures read data and keeps the sticky DMI op status.
// Optional build macro: DMI_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLES stalls).
module dmi_apb_master
  import dmi_pkg::*;
#(
  parameter int unsigned DWIDTH         = 32,
  parameter int unsigned AWIDTH         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              dmi_transfer,
  input  logic [1:0]        dmi_op_in,
  input  logic [AWIDTH-1:0] dmi_address_in,
  input  logic [DWIDTH-1:0] dmi_wdata_in,
  input  logic              dmi_reset,
  input  logic              dmi_hard_reset,
  output logic [DWIDTH-1:0] dmi_rdata_out,
  output logic [1:0]        dmi_op_status,
  output logic              dmi_busy,
  dmi_apb_master_if.master  apb
);

  dmi_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]        status_q, status_d;
  logic              busy_q, busy_d;

  logic [1:0]        status_base_c;
  logic              busy_evt_c;
  logic              fail_evt_c;
  logic              timeout_c;

`ifdef DMI_TIMEOUT_EN
  logic to_clear_c;
  logic to_enable_c;
  logic to_expired;

  // Watchdog restarts in SETUP so each transfer gets a fresh budget.
  assign to_clear_c  = (state_q == ST_SETUP) || dmi_hard_reset;
  assign to_enable_c = (state_q == ST_ACCESS) && !apb.PREADY;

  dmi_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (TCK),
    .rst_n     (TRST),
    .clear_i   (to_clear_c),
    .enable_i  (to_enable_c),
    .expired_o (to_expired)
  );

  assign timeout_c = to_expired;
`else
  // Without the watchdog ACCESS waits for PREADY indefinitely.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_c          = 1'b0;
`endif

  // Next-state, request latching and sticky status update.
  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rdata_d       = rdata_q;
    busy_evt_c    = 1'b0;
    fail_evt_c    = 1'b0;
    // dmi_reset clears before this cycle's request is judged.
    status_base_c = dmi_reset ? 2'(DMI_STAT_OK) : status_q;

    unique case (state_q)
      ST_IDLE: begin
        if (dmi_transfer && (status_base_c == 2'(DMI_STAT_OK))) begin
          if (dmi_op_is_bus(dmi_op_in)) begin
            pwrite_d = (dmi_op_in == 2'(DMI_OP_WRITE));
            paddr_d  = dmi_address_in;
            pwdata_d = dmi_wdata_in;
            state_d  = ST_SETUP;
          end else if (dmi_op_in == 2'(DMI_OP_RSVD)) begin
            fail_evt_c = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        busy_evt_c = dmi_transfer;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        busy_evt_c = dmi_transfer;
        if (apb.PREADY) begin
          state_d = ST_IDLE;
          if (apb.PSLVERR) begin
            fail_evt_c = 1'b1;
          end else if (!pwrite_q) begin
            rdata_d = apb.PRDATA;
          end
        end else if (timeout_c) begin
          state_d    = ST_IDLE;
          fail_evt_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Busy outranks OpFailed outranks the (possibly cleared) current value.
    if (busy_evt_c) begin
      status_d = 2'(DMI_STAT_BUSY);
    end else if (fail_evt_c) begin
      status_d = 2'(DMI_STAT_FAILED);
    end else begin
      status_d = status_base_c;
    end

    // Hard reset wins over everything, including a request in the same cycle.
    if (dmi_hard_reset) begin
      state_d  = ST_IDLE;
      status_d = 2'(DMI_STAT_OK);
      rdata_d  = '0;
      pwrite_d = 1'b0;
      paddr_d  = '0;
      pwdata_d = '0;
    end

    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
    busy_d    = (state_d != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered bus and DMI outputs.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      status_q  <= 2'(DMI_STAT_OK);
      busy_q    <= 1'b0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      busy_q    <= busy_d;
    end
  end

  assign apb.PSEL      = psel_q;
  assign apb.PENABLE   = penable_q;
  assign apb.PWRITE    = pwrite_q;
  assign apb.PADDR     = paddr_q;
  assign apb.PWDATA    = pwdata_q;
  assign dmi_rdata_out = rdata_q;
  assign dmi_op_status = status_q;
  assign dmi_busy      = busy_q;

endmodule

// File: tb/tb_dmi_apb_master.sv
// Bench for dmi_apb_master: directed DMI requests, APB slave model, and a
// scoreboard monitor that checks each completed APB transfer and its DMI result.
module tb_dmi_apb_master;
  import dmi_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          TCK = 1'b0;
  logic          TRST = 1'b0;
  logic          dmi_transfer = 1'b0;
  logic [1:0]    dmi_op_in = 2'd0;
  logic [AW-1:0] dmi_address_in = '0;
  logic [DW-1:0] dmi_wdata_in = '0;
  logic          dmi_reset = 1'b0;
  logic          dmi_hard_reset = 1'b0;
  logic [DW-1:0] dmi_rdata_out;
  logic [1:0]    dmi_op_status;
  logic          dmi_busy;

  always #5 TCK = ~TCK;

  dmi_apb_master_if #(.AWIDTH(AW), .DWIDTH(DW)) apb ();

  dmi_apb_master #(
    .DWIDTH         (DW),
    .AWIDTH         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .TCK            (TCK),
    .TRST           (TRST),
    .dmi_transfer   (dmi_transfer),
    .dmi_op_in      (dmi_op_in),
    .dmi_address_in (dmi_address_in),
    .dmi_wdata_in   (dmi_wdata_in),
    .dmi_reset      (dmi_reset),
    .dmi_hard_reset (dmi_hard_reset),
    .dmi_rdata_out  (dmi_rdata_out),
    .dmi_op_status  (dmi_op_status),
    .dmi_busy       (dmi_busy),
    .apb            (apb)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [1:0]    status;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic pend = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int            cfg_waits = 0;
  logic [DW-1:0] cfg_rdata = '0;
  logic          cfg_err   = 1'b0;
  int            wcnt      = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [DW-1:0] rd, input logic [1:0] st);
    exp_t e;
    e.wr = wr; e.addr = a; e.wdata = d; e.rdata = rd; e.status = st;
    sb.push_back(e);
  endfunction

  // APB slave model plus scoreboard monitor, both on the falling edge.
  always @(negedge TCK) begin
    if (pend) begin
      check("done_rdata",  64'(dmi_rdata_out), 64'(cur.rdata));
      check("done_status", 64'(dmi_op_status), 64'(cur.status));
      check("done_busy",   64'(dmi_busy),      64'd0);
      pend = 1'b0;
    end
    apb.PRDATA  = cfg_rdata;
    apb.PSLVERR = cfg_err;
    if (apb.PSEL && apb.PENABLE) begin
      apb.PREADY = (wcnt >= cfg_waits);
      wcnt++;
      if (apb.PREADY) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_apb: got transfer at addr 0x%0h, required none", apb.PADDR);
        end else begin
          cur = sb.pop_front();
          check("apb_write", 64'(apb.PWRITE), 64'(cur.wr));
          check("apb_addr",  64'(apb.PADDR),  64'(cur.addr));
          if (cur.wr) check("apb_wdata", 64'(apb.PWDATA), 64'(cur.wdata));
          pend = 1'b1;
        end
      end
    end else begin
      apb.PREADY = 1'b0;
      wcnt = 0;
    end
  end

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dmi_transfer   = 1'b1;
    dmi_op_in      = op;
    dmi_address_in = a;
    dmi_wdata_in   = d;
    tick();
    dmi_transfer   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (dmi_busy && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(dmi_busy), 64'd0);
  endtask

  task automatic pulse_dmi_reset();
    dmi_reset = 1'b1;
    tick();
    dmi_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge TCK);
    #1;
    // Reset state
    check("rst_psel",    64'(apb.PSEL),      64'd0);
    check("rst_penable", 64'(apb.PENABLE),   64'd0);
    check("rst_pwrite",  64'(apb.PWRITE),    64'd0);
    check("rst_paddr",   64'(apb.PADDR),     64'd0);
    check("rst_pwdata",  64'(apb.PWDATA),    64'd0);
    check("rst_rdata",   64'(dmi_rdata_out), 64'd0);
    check("rst_status",  64'(dmi_op_status), 64'd0);
    check("rst_busy",    64'(dmi_busy),      64'd0);
    TRST = 1'b1;
    tick();

    // Zero-wait WRITE with cycle-exact phase checks
    cfg_waits = 0;
    push(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 2'd0);
    drive_req(DMI_OP_WRITE, 32'h10, 32'hDEADBEEF);
    check("setup_psel",    64'(apb.PSEL),    64'd1);
    check("setup_penable", 64'(apb.PENABLE), 64'd0);
    check("setup_pwrite",  64'(apb.PWRITE),  64'd1);
    check("setup_paddr",   64'(apb.PADDR),   64'h10);
    check("setup_pwdata",  64'(apb.PWDATA),  64'hDEADBEEF);
    check("setup_busy",    64'(dmi_busy),    64'd1);
    tick();
    check("access_psel_en", 64'({apb.PSEL, apb.PENABLE}), 64'd3);
    tick();
    check("wr_done_psel", 64'(apb.PSEL), 64'd0);
    check("wr_done_busy", 64'(dmi_busy), 64'd0);

    // READ with three wait states
    cfg_waits = 3;
    cfg_rdata = 32'h12345678;
    push(1'b0, 32'h11, 32'h0, 32'h12345678, 2'd0);
    drive_req(DMI_OP_READ, 32'h11, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wait_psel_en", 64'({apb.PSEL, apb.PENABLE}), 64'd3);
      check("wait_paddr",   64'(apb.PADDR), 64'h11);
      tick();
    end
    wait_idle("rd_idle");

    // Second request during ACCESS -> Busy, in-flight read still completes
    cfg_waits = 2;
    cfg_rdata = 32'hA5A5A5A5;
    push(1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 2'd3);
    drive_req(DMI_OP_READ, 32'h20, 32'h0);
    tick();
    drive_req(DMI_OP_WRITE, 32'h30, 32'h33333333);
    check("busy_status", 64'(dmi_op_status), 64'd3);
    wait_idle("busy_idle");
    // Sticky Busy drops the next request
    cfg_rdata = 32'hCCCCCCCC;
    drive_req(DMI_OP_READ, 32'h40, 32'h0);
    check("dropped_psel",   64'(apb.PSEL),      64'd0);
    check("dropped_status", 64'(dmi_op_status), 64'd3);
    pulse_dmi_reset();
    check("clr_status", 64'(dmi_op_status), 64'd0);
    cfg_waits = 0;
    cfg_rdata = 32'h0BADF00D;
    push(1'b0, 32'h44, 32'h0, 32'h0BADF00D, 2'd0);
    drive_req(DMI_OP_READ, 32'h44, 32'h0);
    wait_idle("rd2_idle");

    // PSLVERR read keeps old rdata and fails
    cfg_err   = 1'b1;
    cfg_rdata = 32'hFFFFFFFF;
    push(1'b0, 32'h50, 32'h0, 32'h0BADF00D, 2'd2);
    drive_req(DMI_OP_READ, 32'h50, 32'h0);
    wait_idle("err_idle");
    cfg_err = 1'b0;

    // dmi_reset with a request in the same cycle: clear first, then accept (full-width address)
    push(1'b1, 32'hFFFFFFFC, 32'h80000001, 32'h0BADF00D, 2'd0);
    dmi_reset = 1'b1;
    drive_req(DMI_OP_WRITE, 32'hFFFFFFFC, 32'h80000001);
    dmi_reset = 1'b0;
    check("rstacc_psel", 64'(apb.PSEL), 64'd1);
    wait_idle("rstacc_idle");

    // Reserved op in IDLE
    drive_req(DMI_OP_RSVD, 32'h60, 32'h0);
    check("rsvd_status", 64'(dmi_op_status), 64'd2);
    check("rsvd_psel",   64'(apb.PSEL),      64'd0);
    pulse_dmi_reset();
    check("rsvd_clr", 64'(dmi_op_status), 64'd0);

    // Hard reset during ACCESS, with a simultaneous request
    cfg_waits = 1000;
    drive_req(DMI_OP_READ, 32'h70, 32'h0);
    tick();
    check("pre_hard_penable", 64'(apb.PENABLE), 64'd1);
    dmi_hard_reset = 1'b1;
    dmi_transfer   = 1'b1;
    dmi_op_in      = DMI_OP_WRITE;
    tick();
    dmi_hard_reset = 1'b0;
    dmi_transfer   = 1'b0;
    check("hard_psel",    64'(apb.PSEL),      64'd0);
    check("hard_penable", 64'(apb.PENABLE),   64'd0);
    check("hard_status",  64'(dmi_op_status), 64'd0);
    check("hard_rdata",   64'(dmi_rdata_out), 64'd0);
    check("hard_busy",    64'(dmi_busy),      64'd0);

    // Stalled slave
    drive_req(DMI_OP_READ, 32'h80, 32'h0);
    tick();
`ifdef DMI_TIMEOUT_EN
    n = 0;
    while (apb.PENABLE && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycles", 64'(n), 64'd4);
    check("timeout_status", 64'(dmi_op_status), 64'd2);
    check("timeout_psel",   64'(apb.PSEL), 64'd0);
    pulse_dmi_reset();
`else
    n = 0;
    repeat (100) tick();
    check("stall_psel_en", 64'({apb.PSEL, apb.PENABLE}), 64'd3);
    dmi_hard_reset = 1'b1;
    tick();
    dmi_hard_reset = 1'b0;
    check("stall_abort_psel", 64'(apb.PSEL), 64'd0);
`endif

    // TRST mid-SETUP clears outputs without waiting for a clock
    cfg_waits = 0;
    drive_req(DMI_OP_WRITE, 32'h90, 32'h99);
    check("trst_pre_psel", 64'(apb.PSEL), 64'd1);
    #2;
    TRST = 1'b0;
    #1;
    check("trst_psel",    64'(apb.PSEL),    64'd0);
    check("trst_penable", 64'(apb.PENABLE), 64'd0);
    check("trst_busy",    64'(dmi_busy),    64'd0);
    check("trst_paddr",   64'(apb.PADDR),   64'd0);
    tick();
    TRST = 1'b1;
    tick();
    check("trst_after_psel", 64'(apb.PSEL), 64'd0);

    repeat (2) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
